// File: rtl/stream_demux_1xn.sv
// Registered 1-to-N stream demux with valid/ready handshake, explicit or
// round-robin channel selection and a one-entry holding register per channel.

module stream_demux_ch #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid
);
  logic [DATA_W-1:0] r_data;
  logic              r_valid;

  // A load in the drain cycle keeps the slot full with the new beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_data  <= i_data;
      r_valid <= 1'b1;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;
endmodule

module stream_demux_1xn #(
  parameter int DATA_W = 8,
  parameter int SEL_W  = 3,
  localparam int N     = 1 << SEL_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [SEL_W-1:0]    sel,
  input  logic                mode,
  output logic [N*DATA_W-1:0] out_data,
  output logic [N-1:0]        out_valid,
  input  logic [N-1:0]        out_ready,
  output logic [SEL_W-1:0]    cur_ch
);
  logic [SEL_W-1:0]          r_ptr;
  logic [SEL_W-1:0]          w_tgt;
  logic                      w_accept;
  logic [N-1:0]              w_valid;
  logic [N-1:0][DATA_W-1:0]  w_data;

  assign w_tgt    = mode ? r_ptr : sel;
  assign cur_ch   = w_tgt;
  assign in_ready = ~w_valid[w_tgt] | out_ready[w_tgt];
  assign w_accept = in_valid & in_ready;

  // Strict order: the pointer never skips a stalled channel; N is a power of
  // two so the natural SEL_W-bit wrap gives modulo-N.
  always_ff @(posedge clk) begin
    if (!rst_n)
      r_ptr <= '0;
    else if (w_accept && mode)
      r_ptr <= r_ptr + SEL_W'(1);
  end

  for (genvar k = 0; k < N; k++) begin : g_ch
    stream_demux_ch #(.DATA_W(DATA_W)) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_load  (w_accept && (w_tgt == SEL_W'(k))),
      .i_data  (in_data),
      .i_ready (out_ready[k]),
      .o_data  (w_data[k]),
      .o_valid (w_valid[k])
    );
  end

  assign out_data  = w_data;
  assign out_valid = w_valid;
endmodule

// File: tb/tb_stream_demux_1xn.sv
// Self-checking bench for stream_demux_1xn: directed scenarios plus random
// traffic compared every cycle against a per-channel slot model.

module tb_stream_demux_1xn;
  localparam int DATA_W = 8;
  localparam int SEL_W  = 3;
  localparam int N      = 1 << SEL_W;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [DATA_W-1:0]   in_data;
  logic                in_valid;
  logic                in_ready;
  logic [SEL_W-1:0]    sel;
  logic                mode;
  logic [N*DATA_W-1:0] out_data;
  logic [N-1:0]        out_valid;
  logic [N-1:0]        out_ready;
  logic [SEL_W-1:0]    cur_ch;

  stream_demux_1xn #(.DATA_W(DATA_W), .SEL_W(SEL_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .sel(sel), .mode(mode), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .cur_ch(cur_ch)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model: one slot per channel plus the round-robin pointer.
  bit [DATA_W-1:0] m_data [N];
  bit              m_valid[N];
  int              m_ptr;
  bit              last_acc;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < N; k++) begin
      m_data[k]  = '0;
      m_valid[k] = 1'b0;
    end
    m_ptr = 0;
  endtask

  // One clock: check combinational outputs, advance the model across the
  // edge, then check every registered output against the model.
  task automatic cycle();
    int t;
    bit rdy;
    bit [DATA_W-1:0] n_data [N];
    bit              n_valid[N];
    int              n_ptr;
    logic [N-1:0]        exp_v;
    logic [N*DATA_W-1:0] exp_d;
    #1;
    t   = mode ? m_ptr : int'(sel);
    rdy = !m_valid[t] || out_ready[t];
    chk("cur_ch", cur_ch, t);
    chk("in_ready", in_ready, rdy);
    last_acc = rst_n && in_valid && rdy;
    n_ptr = m_ptr;
    for (int k = 0; k < N; k++) begin
      n_data[k]  = m_data[k];
      n_valid[k] = m_valid[k] && !out_ready[k];
      if (last_acc && k == t) begin
        n_data[k]  = in_data;
        n_valid[k] = 1'b1;
      end
    end
    if (last_acc && mode) n_ptr = (m_ptr + 1) % N;
    @(posedge clk);
    #1;
    if (!rst_n) model_clear();
    else begin
      for (int k = 0; k < N; k++) begin
        m_data[k]  = n_data[k];
        m_valid[k] = n_valid[k];
      end
      m_ptr = n_ptr;
    end
    for (int k = 0; k < N; k++) begin
      exp_v[k] = m_valid[k];
      exp_d[k*DATA_W +: DATA_W] = m_data[k];
    end
    chk("out_valid", out_valid, exp_v);
    chk("out_data", out_data, exp_d);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; sel = 3'd0; mode = 1'b0;
    out_ready = '1;
    @(posedge clk); #1;
    model_clear();
    rst_n = 1'b1;
    #1;
    chk("rst out_valid", out_valid, 0);
    chk("rst out_data", out_data, 0);
    chk("rst in_ready", in_ready, 1);
    chk("rst cur_ch", cur_ch, 0);

    // Explicit routing
    in_valid = 1; in_data = 8'hA5; sel = 3'd5;
    cycle();
    chk("route valid", out_valid, 8'b0010_0000);
    chk("route data", out_data[5*8 +: 8], 8'hA5);
    in_valid = 0;
    cycle();
    chk("route pulse", out_valid, 0);

    // Backpressure and retarget
    out_ready = 8'hFB; sel = 3'd2; in_valid = 1; in_data = 8'h11;
    cycle();
    in_data = 8'h22; #1;
    chk("bp in_ready", in_ready, 0);
    cycle();
    chk("bp hold", out_data[2*8 +: 8], 8'h11);
    sel = 3'd3; #1;
    chk("bp retarget rdy", in_ready, 1);
    cycle();
    chk("bp ch3 data", out_data[3*8 +: 8], 8'h22);
    chk("bp valid", out_valid, 8'b0000_1100);
    in_valid = 0; out_ready = '1;
    cycle();
    chk("bp drained", out_valid, 0);

    // Simultaneous drain and load
    out_ready = 8'hEF; sel = 3'd4; in_valid = 1; in_data = 8'h33;
    cycle();
    out_ready = '1; in_data = 8'h44; #1;
    chk("dl in_ready", in_ready, 1);
    cycle();
    chk("dl valid", out_valid, 8'b0001_0000);
    chk("dl data", out_data[4*8 +: 8], 8'h44);
    in_valid = 0;
    cycle();

    // Round-robin wrap
    mode = 1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1; in_data = 8'(i); #1;
      chk("rr cur_ch", cur_ch, i % 8);
      cycle();
      chk("rr valid", out_valid, 1 << (i % 8));
      chk("rr data", out_data[(i % 8)*8 +: 8], i);
    end
    in_valid = 0; #1;
    chk("rr cur_ch end", cur_ch, 2);
    cycle();

    // Round-robin stall and mode switch
    in_valid = 1; in_data = 8'h5A;
    cycle();                                 // ptr 2 -> 3
    mode = 0; sel = 3'd3; out_ready = 8'hF7; in_data = 8'h66;
    cycle();                                 // ch3 full, stalled
    mode = 1; in_data = 8'h99; #1;
    chk("stall rdy", in_ready, 0);
    chk("stall cur_ch", cur_ch, 3);
    cycle();
    cycle();
    chk("stall ptr", cur_ch, 3);
    chk("stall ch3", out_data[3*8 +: 8], 8'h66);
    mode = 0; sel = 3'd6; in_data = 8'h77; #1;
    chk("switch rdy", in_ready, 1);
    cycle();
    chk("switch ch6", out_data[6*8 +: 8], 8'h77);
    chk("switch valid", out_valid, 8'b0100_1000);
    in_valid = 0; mode = 1; #1;
    chk("switch back", cur_ch, 3);
    out_ready = '1;
    cycle();

    // Reset mid-operation
    mode = 0; out_ready = '0; in_valid = 1;
    sel = 3'd1; in_data = 8'h12; cycle();
    sel = 3'd7; in_data = 8'h13; cycle();
    chk("pre-rst valid", out_valid, 8'b1000_0010);
    rst_n = 0; sel = 3'd2; in_data = 8'hEE;
    cycle();
    chk("mid-rst valid", out_valid, 0);
    chk("mid-rst data", out_data, 0);
    rst_n = 1; in_valid = 0; mode = 1; #1;
    chk("mid-rst ptr", cur_ch, 0);
    cycle();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if (!(in_valid && !last_acc)) in_data = 8'($urandom);
      in_valid  = ($urandom_range(0, 3) != 0);
      sel       = 3'($urandom);
      mode      = ($urandom_range(0, 2) == 0) ? ~mode : mode;
      out_ready = 8'($urandom | $urandom);
      rst_n     = ($urandom_range(0, 299) != 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/stream_demux_1xn.md
# stream_demux_1xn

Registered, parametrised 1-to-N stream demultiplexer with valid/ready handshaking on the input and on every output channel. One input beat goes to exactly one of N = 2**SEL_W output channels. The channel comes either from an explicit select or from an internal round-robin pointer. This block is the next generation of the combinational 1x8 demux tree: it generalises width and channel count, registers every output and adds backpressure and an auto-sequencing mode. It sits between a single producer and N independent consumers.

## Interface
- DATA_W, 8, width of a data beat (≥1)
- SEL_W, 3, select width; channel count N = 2**SEL_W (1..5)
- clk  in  1  rising-edge clock; the block's only clock
- rst_n  in  1  synchronous, active-low reset, sampled on rising clk
- in_data  in  DATA_W  input beat
- in_valid  in  1  input beat present
- in_ready  out  1  block can accept the beat this cycle
- sel  in  SEL_W  explicit channel select, used when mode=0
- mode  in  1  0 = explicit select, 1 = round-robin pointer
- out_data  out  N*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W]
- out_valid  out  N  per-channel beat present
- out_ready  in  N  per-channel consumer accepts
- cur_ch  out  SEL_W  channel the next input beat targets

## Operation
- Target channel t = sel when mode=0, else t = ptr (internal SEL_W-bit register). cur_ch = t, combinational.
- Each channel has a one-entry holding register with fields data_k and valid_k. out_data and out_valid drive these registers directly; no combinational path from in_data to out_data.
- in_ready = ~valid_t | out_ready[t]. The target register is either empty or drained in the same cycle.
- Accept: when in_valid & in_ready, load data_t ← in_data and set valid_t ← 1.
- Drain: when valid_k & out_ready[k], clear valid_k ← 0, unless channel k is loaded in the same cycle. Load wins, so the register stays full with new data.
- Non-target channels are never written by an accept. Each drains independently of the input and of the other channels.
- data_k holds its last loaded value after a drain. Consumers qualify data with out_valid[k] only.
- Pointer (mode=1): on each accept, ptr ← ptr+1 modulo N, so N-1 wraps to 0. The pointer holds when there is no accept.
- Pointer (mode=0): ptr holds its value and resumes from it when mode returns to 1.
- Stall: if the target is full and not draining, in_ready=0 and nothing changes. In mode=1 the pointer does not skip to a free channel; strict order is required.
- sel and mode may change every cycle. Both are sampled only in the accept cycle.
- N=1 (SEL_W=0 is not supported): SEL_W ≥1 is required.

## Timing
- Reset (rst_n=0 at a rising edge): all valid_k=0, all data_k=0, ptr=0. Outputs after that edge: out_valid=0, out_data=0, in_ready=1, and cur_ch = sel (mode=0) or 0 (mode=1).
- Reset mid-transfer discards all held beats. A beat presented in the reset cycle is not accepted, regardless of in_ready.
- Latency: a beat accepted at edge n is visible on out_valid[t] and out_data after edge n, i.e. in cycle n+1.
- Throughput: 1 beat/cycle into any channel whose consumer holds out_ready=1, including back-to-back beats into the same channel.
- in_ready depends combinationally on sel, mode, ptr, valid_t and out_ready[t]. It does not depend on in_valid.
- Producer rule: once in_valid=1, the producer keeps in_data stable until the handshake. Sel stability is not required; a changed sel retargets the beat.

## Test plan
- Reset/explicit routing: DATA_W=8, SEL_W=3, all out_ready=1. After rst_n low then high, send 0xA5 with sel=5. Expect out_valid=8'b0010_0000 and channel 5 data=0xA5 one cycle later; the valid pulse lasts one cycle.
- Backpressure: out_ready[2]=0, send 0x11 then 0x22 to sel=2. Expect 0x11 held on channel 2 and in_ready=0 with 0x22 pending. Set sel=3 with 0x22 still pending: expect in_ready=1 and 0x22 lands on channel 3. Raise out_ready[2]: channel 2 drains.
- Simultaneous drain and load: channel 4 full with 0x33 and out_ready[4]=1. Send 0x44 to sel=4 in the same cycle. Expect in_ready=1, out_valid[4] stays 1 and the next cycle shows data=0x44.
- Round-robin wrap: mode=1, all ready, send 10 beats 0x00..0x09. Expect channels 0..7, then 0 and 1 again. cur_ch sequence 0,1,…,7,0,1,2.
- Round-robin stall and mode switch: mode=1 with ptr=3 and out_ready[3]=0 and channel 3 full. Expect in_ready=0 and ptr stays 3. Switch to mode=0 with sel=6, send 0x77: expect it on channel 6 and ptr still 3. Return to mode=1: cur_ch=3.
- Reset mid-operation: channels 1 and 7 full with out_ready=0. Assert rst_n=0 for one edge while in_valid=1. Expect out_valid=0, out_data=0 and ptr=0 after that edge, with no beat accepted in that cycle.
